// File: rtl/npc_gen_if.sv
// Program-counter control bus: control-flow events in, next fetch address and status out.
interface npc_gen_if;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        excp;
  logic [31:0] newPC;
  logic        pending;
  logic        addr_err;

  modport master (
    output pc, stall, br_taken, br_target, jump, jump_target, excp,
    input  newPC, pending, addr_err
  );

  modport slave (
    input  pc, stall, br_taken, br_target, jump, jump_target, excp,
    output newPC, pending, addr_err
  );
endinterface

// File: rtl/npc_gen.sv
// Next-PC generator: picks the next fetch address and buffers redirects that arrive while stalled.
// Optional macro NPC_DELAY_SLOT_EN adds MIPS branch-delay-slot sequencing via a SLOT state.
module npc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic       clk,
  input  logic       reset,
  npc_gen_if.slave   bus
);

  typedef enum logic [1:0] {RUN, PEND, SLOT} state_t;

  state_t      state_q;
  logic [31:0] tgt_q;
  logic        addr_err_q;

  logic        req;
  logic [31:0] req_raw;
  logic [31:0] req_tgt;
  logic        misaligned;
  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Jump beats branch; targets are word-aligned before use or storage.
  assign req        = bus.jump | bus.br_taken;
  assign req_raw    = bus.jump ? bus.jump_target : bus.br_target;
  assign req_tgt    = {req_raw[31:2], 2'b00};
  assign misaligned = |req_raw[1:0];
  assign accept     = req & ~bus.excp & (state_q == RUN);
  assign pc_plus4   = bus.pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (reset) begin
      next_pc = RESET_VECTOR;
    end else if (bus.excp) begin
      next_pc = EXC_VECTOR;
    end else if (bus.stall) begin
      next_pc = bus.pc;
    end else begin
      case (state_q)
`ifdef NPC_DELAY_SLOT_EN
        PEND:    next_pc = pc_plus4;
`else
        PEND:    next_pc = tgt_q;
`endif
        SLOT:    next_pc = tgt_q;
        default: begin
`ifdef NPC_DELAY_SLOT_EN
          next_pc = pc_plus4;
`else
          if (req) next_pc = req_tgt;
`endif
        end
      endcase
    end
  end

  // Requests arriving outside RUN are wrong-path and dropped; the buffered target wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      tgt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= accept & misaligned;
      if (bus.excp) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (req) begin
              tgt_q <= req_tgt;
`ifdef NPC_DELAY_SLOT_EN
              state_q <= bus.stall ? PEND : SLOT;
`else
              if (bus.stall) state_q <= PEND;
`endif
            end
          end
          PEND: begin
`ifdef NPC_DELAY_SLOT_EN
            if (!bus.stall) state_q <= SLOT;
`else
            if (!bus.stall) state_q <= RUN;
`endif
          end
          SLOT: begin
            if (!bus.stall) state_q <= RUN;
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign bus.newPC    = next_pc;
  assign bus.pending  = (state_q == PEND);
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_npc_gen.sv
// Scoreboard bench for npc_gen: directed vectors push expectations, a negedge monitor pops and compares.
module tb_npc_gen;

  localparam logic [2:0] M_ALL = 3'b111;
  localparam logic [2:0] M_NPC = 3'b100;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        pend;
    logic        aerr;
    logic [2:0]  mask;
  } exp_t;

  logic clk;
  logic reset;
  npc_gen_if bus ();

  exp_t sb[$];
  exp_t mon_e;
  int   checks_total  = 0;
  int   checks_passed = 0;

  npc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input string name, input logic rst, input logic [31:0] pc,
                               input logic stall, input logic br, input logic [31:0] brt,
                               input logic jmp, input logic [31:0] jt, input logic excp,
                               input logic [31:0] e_npc, input logic e_pend, input logic e_aerr,
                               input logic [2:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.pc          = pc;
    bus.stall       = stall;
    bus.br_taken    = br;
    bus.br_target   = brt;
    bus.jump        = jmp;
    bus.jump_target = jt;
    bus.excp        = excp;
    e.name = name;
    e.npc  = e_npc;
    e.pend = e_pend;
    e.aerr = e_aerr;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.mask[2]) begin
      checks_total++;
      if (bus.newPC === e.npc) checks_passed++;
      else $display("[TB] FAIL %s newPC: got %h expected %h", e.name, bus.newPC, e.npc);
    end
    if (e.mask[1]) begin
      checks_total++;
      if (bus.pending === e.pend) checks_passed++;
      else $display("[TB] FAIL %s pending: got %b expected %b", e.name, bus.pending, e.pend);
    end
    if (e.mask[0]) begin
      checks_total++;
      if (bus.addr_err === e.aerr) checks_passed++;
      else $display("[TB] FAIL %s addr_err: got %b expected %b", e.name, bus.addr_err, e.aerr);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    reset = 1'b1;
    bus.pc = '0; bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.excp = 0;

    //              name          rst pc            stl br brt           jmp jt            exc  newPC         pnd aerr mask
    applyStimulus("reset0",       1, 32'h10,        0, 0, 32'h0,        0, 32'h0,        0,  32'h0,        0, 0, M_NPC);
    applyStimulus("reset1",       1, 32'h10,        0, 0, 32'h0,        0, 32'h0,        0,  32'h0,        0, 0, M_ALL);
`ifdef NPC_DELAY_SLOT_EN
    applyStimulus("br_slot",      0, 32'h100,       0, 1, 32'h300,      0, 32'h0,        0,  32'h104,      0, 0, M_ALL);
    applyStimulus("slot_tgt",     0, 32'h104,       0, 0, 32'h0,        1, 32'h900,      0,  32'h300,      0, 0, M_ALL);
    applyStimulus("slot_drop",    0, 32'h300,       0, 0, 32'h0,        0, 32'h0,        0,  32'h304,      0, 0, M_ALL);
    applyStimulus("jmp_slot",     0, 32'h304,       0, 0, 32'h0,        1, 32'h500,      0,  32'h308,      0, 0, M_ALL);
    applyStimulus("slot_stall",   0, 32'h308,       1, 0, 32'h0,        0, 32'h0,        0,  32'h308,      0, 0, M_ALL);
    applyStimulus("slot_go",      0, 32'h308,       0, 0, 32'h0,        0, 32'h0,        0,  32'h500,      0, 0, M_ALL);
    applyStimulus("seq_500",      0, 32'h500,       0, 0, 32'h0,        0, 32'h0,        0,  32'h504,      0, 0, M_ALL);
    applyStimulus("stall_br",     0, 32'h504,       1, 1, 32'h700,      0, 32'h0,        0,  32'h504,      0, 0, M_ALL);
    applyStimulus("pend_slot",    0, 32'h504,       0, 0, 32'h0,        0, 32'h0,        0,  32'h508,      1, 0, M_ALL);
    applyStimulus("pend_tgt",     0, 32'h508,       0, 0, 32'h0,        0, 32'h0,        0,  32'h700,      0, 0, M_ALL);
    applyStimulus("seq_700",      0, 32'h700,       0, 0, 32'h0,        0, 32'h0,        0,  32'h704,      0, 0, M_ALL);
    applyStimulus("jmp_slot2",    0, 32'h704,       0, 0, 32'h0,        1, 32'h900,      0,  32'h708,      0, 0, M_ALL);
    applyStimulus("excp_slot",    0, 32'h708,       0, 0, 32'h0,        0, 32'h0,        1,  32'h8000_0180, 0, 0, M_ALL);
    applyStimulus("after_excp",   0, 32'h8000_0180, 0, 0, 32'h0,        0, 32'h0,        0,  32'h8000_0184, 0, 0, M_ALL);
`else
    applyStimulus("seq_10",       0, 32'h10,        0, 0, 32'h0,        0, 32'h0,        0,  32'h14,       0, 0, M_ALL);
    applyStimulus("wrap",         0, 32'hFFFF_FFFC, 0, 0, 32'h0,        0, 32'h0,        0,  32'h0,        0, 0, M_ALL);
    applyStimulus("jmp_vs_br",    0, 32'h20,        0, 1, 32'h800,      1, 32'h400,      0,  32'h400,      0, 0, M_ALL);
    applyStimulus("stall_br",     0, 32'h20,        1, 1, 32'h1000,     0, 32'h0,        0,  32'h20,       0, 0, M_ALL);
    applyStimulus("pend_hold",    0, 32'h20,        1, 0, 32'h0,        0, 32'h0,        0,  32'h20,       1, 0, M_ALL);
    applyStimulus("pend_jmp",     0, 32'h20,        1, 0, 32'h0,        1, 32'h2000,     0,  32'h20,       1, 0, M_ALL);
    applyStimulus("pend_go",      0, 32'h20,        0, 1, 32'h3000,     0, 32'h0,        0,  32'h1000,     1, 0, M_ALL);
    applyStimulus("after_pend",   0, 32'h1000,      0, 0, 32'h0,        0, 32'h0,        0,  32'h1004,     0, 0, M_ALL);
    applyStimulus("stall_br2",    0, 32'h1004,      1, 1, 32'h1000,     0, 32'h0,        0,  32'h1004,     0, 0, M_ALL);
    applyStimulus("excp_pend",    0, 32'h1004,      1, 0, 32'h0,        0, 32'h0,        1,  32'h8000_0180, 1, 0, M_ALL);
    applyStimulus("after_excp",   0, 32'h8000_0180, 0, 0, 32'h0,        0, 32'h0,        0,  32'h8000_0184, 0, 0, M_ALL);
    applyStimulus("mis_jmp",      0, 32'h8000_0184, 0, 0, 32'h0,        1, 32'h403,      0,  32'h400,      0, 0, M_ALL);
    applyStimulus("aerr_pulse",   0, 32'h400,       0, 0, 32'h0,        0, 32'h0,        0,  32'h404,      0, 1, M_ALL);
    applyStimulus("aerr_clear",   0, 32'h404,       0, 0, 32'h0,        0, 32'h0,        0,  32'h408,      0, 0, M_ALL);
    applyStimulus("mis_stall",    0, 32'h408,       1, 1, 32'h502,      0, 32'h0,        0,  32'h408,      0, 0, M_ALL);
    applyStimulus("mis_pend_go",  0, 32'h408,       0, 0, 32'h0,        0, 32'h0,        0,  32'h500,      1, 1, M_ALL);
    applyStimulus("seq_500",      0, 32'h500,       0, 0, 32'h0,        0, 32'h0,        0,  32'h504,      0, 0, M_ALL);
    applyStimulus("rst_vs_excp",  1, 32'h504,       0, 0, 32'h0,        0, 32'h0,        1,  32'h0,        0, 0, M_NPC);
    applyStimulus("excp_vs_jmp",  0, 32'h504,       0, 0, 32'h0,        1, 32'h7,        1,  32'h8000_0180, 0, 0, M_ALL);
    applyStimulus("no_aerr",      0, 32'h8000_0180, 0, 0, 32'h0,        0, 32'h0,        0,  32'h8000_0184, 0, 0, M_ALL);
`endif

    for (int i = 0; i < 8; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      checks_total++;
      $display("[TB] FAIL drain: got %0d queued expectations, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
